// File: rtl/mdu_unit.sv
// mdu_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Multiply waits a fixed latency, then writes the full-width product. Divide
// runs one restoring step per cycle, then spends one cycle on sign fixup.
module mdu_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;     // multiplicand, or original dividend for divide-by-zero
  logic [WIDTH-1:0] b_q;     // multiplier, or divisor magnitude
  logic             sgn_q;   // signed multiply
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;   // holds dividend magnitude, shifted out as quotient bits enter
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, prod;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   rem_d, quo_d;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;

  // Full-width product of latched operands; sign extension gives signed result.
  always_comb begin
    mul_a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = mul_a_ext * mul_b_ext;
  end

  // Operand magnitudes at launch; DIV (op[0]=0) is signed, DIVU is not.
  always_comb begin
    a_neg_in = ~op[0] & a[WIDTH-1];
    b_neg_in = ~op[0] & b[WIDTH-1];
    a_mag_in = a_neg_in ? -a : a;
    b_mag_in = b_neg_in ? -b : b;
  end

  // One restoring-division step plus the final sign fixup.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    q_fix = qneg_q ? -quo_q : quo_q;
    r_fix = rneg_q ? -rem_q : rem_q;
  end

  // Control FSM, operand latches and architectural HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_q     <= a;
                b_q     <= b;
                sgn_q   <= (op == OP_MULT);
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                a_q     <= a;
                b_q     <= b_mag_in;
                quo_q   <= a_mag_in;
                rem_q   <= '0;
                qneg_q  <= a_neg_in ^ b_neg_in;
                rneg_q  <= a_neg_in;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= DIV;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt_q == MUL_LAST) begin
            hi_q    <= prod[2*WIDTH-1:WIDTH];
            lo_q    <= prod[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV: begin
          if (cnt_q == DIV_LAST) begin
            // Zero divisor: report all-ones quotient and the untouched dividend.
            if (b_q == '0) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: transaction-level reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_mdu_unit;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned MUL_CYCLES = 4;
  localparam int          DIV_LAT    = WIDTH + 1;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  mdu_unit #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sq, sr;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      3'd1: begin
        up = {32'h0, x} * {32'h0, y};
        return up;
      end
      3'd2: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      3'd3: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Reference model: latency countdown per accepted operation.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_res = '0;
  int          m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_res;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        case (op)
          3'd0, 3'd1: begin m_res = ref_op(op, a, b); m_busy = 1'b1; m_left = MUL_CYCLES; end
          3'd2, 3'd3: begin m_res = ref_op(op, a, b); m_busy = 1'b1; m_left = DIV_LAT; end
          3'd4: m_hi = a;
          3'd5: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc busy", {31'h0, busy}, {31'h0, m_busy});
    check("cyc done", {31'h0, done}, {31'h0, m_done});
    check("cyc hi", hi, m_hi);
    check("cyc lo", lo, m_lo);
    check("cyc done_with_busy", {31'h0, done & busy}, 32'h0);
  end

  // Caller is at a negedge; start is held for exactly one rising edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
  endtask

  task automatic finish_op(input string name, input int exp_cyc, input logic exp_done,
                           input logic [31:0] eh, input logic [31:0] el);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, n, exp_cyc);
    check({name, " done"}, {31'h0, done}, {31'h0, exp_done});
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    @(negedge clk);
    check({name, " done_pulse_end"}, {31'h0, done}, 32'h0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_cyc, input logic exp_done,
                        input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    launch(o, x, y);
    finish_op(name, exp_cyc, exp_done, eh, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int          n;

    // Pin the model with hand-computed values.
    r = ref_op(3'd0, 32'hFFFFFFFD, 32'd7);
    check("model mult", r[31:0], 32'hFFFFFFEB);
    r = ref_op(3'd2, 32'hFFFFFFF9, 32'd2);
    check("model div lo", r[31:0], 32'hFFFFFFFD);
    check("model div hi", r[63:32], 32'hFFFFFFFF);
    r = ref_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("model multu hi", r[63:32], 32'hFFFFFFFE);

    repeat (2) @(negedge clk);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    rst = 1'b1;

    run_op("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'd7, 4, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 1'b1, 32'hFFFFFFFE, 32'h1);
    run_op("mult_m1xm1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 1'b1, 32'h0, 32'h1);
    run_op("div_neg7by2", 3'd2, 32'hFFFFFFF9, 32'd2, 33, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_100by7", 3'd3, 32'd100, 32'd7, 33, 1'b1, 32'd2, 32'd14);
    run_op("divu_by0", 3'd3, 32'h12345678, 32'h0, 33, 1'b1, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_by0", 3'd2, 32'hFFFFFFF0, 32'h0, 33, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33, 1'b1, 32'h0, 32'h80000000);
    run_op("mthi", 3'd4, 32'hCAFEF00D, 32'h0, 0, 1'b0, 32'hCAFEF00D, 32'h80000000);
    run_op("mtlo", 3'd5, 32'h0BADBEEF, 32'h0, 0, 1'b0, 32'hCAFEF00D, 32'h0BADBEEF);
    run_op("nop6", 3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'hCAFEF00D, 32'h0BADBEEF);
    run_op("nop7", 3'd7, 32'h11111111, 32'h2, 0, 1'b0, 32'hCAFEF00D, 32'h0BADBEEF);

    // Start while busy: MULT request mid-DIV must be ignored.
    @(negedge clk);
    launch(3'd2, 32'd1000, 32'hFFFFFFF9);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start hi_held", hi, 32'hCAFEF00D);
    finish_op("div_ignore_mult", 29, 1'b1, 32'd6, 32'hFFFFFF72);

    // Back-to-back: new op launched in the done cycle.
    @(negedge clk);
    launch(3'd1, 32'd3, 32'd5);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("b2b mul busy_cycles", n, 4);
    check("b2b mul done", {31'h0, done}, 32'h1);
    check("b2b mul lo", lo, 32'd15);
    launch(3'd3, 32'd100, 32'd7);
    check("b2b div busy", {31'h0, busy}, 32'h1);
    finish_op("b2b_divu", 33, 1'b1, 32'd2, 32'd14);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    launch(3'd2, 32'h12345678, 32'd3);
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_op("post_reset_mult", 3'd0, 32'd6, 32'd7, 4, 1'b1, 32'h0, 32'd42);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers; executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the single-cycle MIPS core.
- Sits beside the ALU, downstream of the register file: operand A comes from rs read data and operand B from rt read data.
- Owns a busy/done handshake so the control unit can stall PC and register-file writes while a multi-cycle operation runs.
- HI/LO outputs feed the register-file write-data mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 4, fixed multiply latency in cycles; legal range 1..WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request; sampled only while busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  high while a MUL or DIV operation is in flight.
- done  out  1  one-cycle pulse in the cycle in which HI/LO take a MUL or DIV result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0; counter and operand latches cleared.
- Reset asserted mid-operation aborts it. No partial result is written. Outputs return to reset values immediately.
- States: IDLE, MUL, DIV.
- IDLE + start + MULT/MULTU:
  - Latch a, b and signedness at edge T.
  - Go to MUL. busy=1 from T+1.
  - The 2*WIDTH-bit product is written at edge T+MUL_CYCLES: hi=upper half, lo=lower half.
  - In the cycle following that edge: busy=0, done=1, state IDLE.
- IDLE + start + DIV/DIVU:
  - Latch a, b at edge T. Signed ops convert both operands to magnitudes.
  - Go to DIV. One restoring-division step per cycle for WIDTH cycles, then one sign-fixup cycle.
  - Result written at edge T+WIDTH+1; busy and done then behave as for multiply.
- Signed divide rules:
  - Quotient truncates toward zero; quotient goes to lo.
  - Remainder takes the sign of the dividend; remainder goes to hi.
- Divide by zero (b=0), signed or unsigned: full latency; lo=all ones, hi=a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- IDLE + start + MTHI: hi=a at the next edge; lo unchanged; busy stays 0; no done pulse. MTLO is symmetric and writes lo.
- IDLE + start + op 110/111: no state change.
- start while busy=1 is ignored completely: no latch and no restart. The control unit stalls instead.
- Operand inputs may change freely after the start edge; only latched copies are used.
- hi/lo hold their previous values throughout busy; they change only at result write, MTHI/MTLO, or reset.
- Back-to-back: start may be asserted in the same cycle done=1 (busy=0). The new op launches at that edge with no idle bubble.
- done is never asserted while busy=1.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high for 4 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for exactly one cycle.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 4 cycles. MULT with the same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 33 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xCAFEF00D -> hi updated next edge, busy never rises, no done pulse. Then start MULT while a DIV is busy -> ignored; DIV result still correct.
- Start DIV, drop rst at cycle 10 -> hi=lo=0 and busy=0 immediately. After release, MULT 6*7 -> lo=42 with no residue from the aborted op.
